// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: padder FSM states, block geometry, padding marker
// and the initial hash words used by the compression core and digest wrapper.
package sha1_pkg;

  localparam int          SHA1_BLK_W    = 512;
  localparam int          SHA1_WORDS    = 16;
  localparam logic [31:0] SHA1_PAD_WORD = 32'h8000_0000;

  localparam logic [31:0] SHA1_H0 = 32'h6745_2301;
  localparam logic [31:0] SHA1_H1 = 32'hEFCD_AB89;
  localparam logic [31:0] SHA1_H2 = 32'h98BA_DCFE;
  localparam logic [31:0] SHA1_H3 = 32'h1032_5476;
  localparam logic [31:0] SHA1_H4 = 32'hC3D2_E1F0;

  typedef enum logic [2:0] {
    ST_FILL   = 3'd0,
    ST_PAD    = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_LEN_LO = 3'd3,
    ST_SEND   = 3'd4,
    ST_WAIT   = 3'd5
  } state_t;

endpackage

// File: rtl/sha1_last_word_pack.sv
// Final message word shaping: keeps the valid leading bytes, appends the 0x80
// marker right after them, or flags that the marker belongs in the next word.
module sha1_last_word_pack
  import sha1_pkg::*;
(
  input  logic [31:0] din_i,
  input  logic [2:0]  bytes_i,
  output logic [31:0] word_o,
  output logic        pend80_o,
  output logic [2:0]  nbytes_o
);

  always_comb begin
    word_o   = din_i;
    pend80_o = 1'b0;
    nbytes_o = bytes_i;
    case (bytes_i)
      3'd0: word_o = SHA1_PAD_WORD;
      3'd1: word_o = {din_i[31:24], 24'h80_0000};
      3'd2: word_o = {din_i[31:16], 16'h8000};
      3'd3: word_o = {din_i[31:8], 8'h80};
      default: begin
        // Full word (values above 4 are treated as 4): marker goes in the next word.
        word_o   = din_i;
        pend80_o = 1'b1;
        nbytes_o = 3'd4;
      end
    endcase
  end

endmodule

// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder: packs a big-endian word stream into padded 512-bit
// blocks and hands them one at a time to the compression core.
module sha1_msg_padder
  import sha1_pkg::*;
#(
  parameter int LEN_W     = 64,
  parameter int BLK_WORDS = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [31:0]  DIN,
  input  logic         DIN_VALID,
  input  logic         DIN_LAST,
  input  logic [2:0]   DIN_BYTES,
  output logic         DIN_READY,
  output logic [511:0] BLK_OUT,
  output logic         BLK_START,
  output logic         BLK_FIRST,
  output logic         BLK_LAST,
  input  logic         CORE_DONE,
  output logic         MSG_DONE,
  output logic         BUSY,
  output logic [2:0]   dbg_state_o
);

  state_t             state_q, state_d;
  logic [3:0]         widx_q, widx_d;
  logic [LEN_W-1:0]   bitlen_q, bitlen_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic               pend80_q, pend80_d;
  logic               resume_pad_q, resume_pad_d;
  logic               busy_q, busy_d;
  logic               done_prev_q;
  logic [31:0]        buf_q [BLK_WORDS];

  logic               wr_en, buf_clr, done_rise;
  logic [3:0]         wr_idx;
  logic [31:0]        wr_data;
  logic [31:0]        pack_word;
  logic               pack_pend80;
  logic [2:0]         pack_nbytes;
  logic [63:0]        len64;

  sha1_last_word_pack u_pack (
    .din_i    (DIN),
    .bytes_i  (DIN_BYTES),
    .word_o   (pack_word),
    .pend80_o (pack_pend80),
    .nbytes_o (pack_nbytes)
  );

  assign len64     = 64'(bitlen_q);
  assign done_rise = CORE_DONE & ~done_prev_q;

  always_comb begin
    state_d      = state_q;
    widx_d       = widx_q;
    bitlen_d     = bitlen_q;
    first_d      = first_q;
    last_d       = last_q;
    pend80_d     = pend80_q;
    resume_pad_d = resume_pad_q;
    busy_d       = busy_q;
    wr_en        = 1'b0;
    wr_idx       = widx_q;
    wr_data      = '0;
    buf_clr      = 1'b0;
    MSG_DONE     = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (DIN_VALID) begin
          wr_en  = 1'b1;
          busy_d = 1'b1;
          last_d = 1'b0;
          if (!DIN_LAST) begin
            wr_data      = DIN;
            bitlen_d     = bitlen_q + LEN_W'(32);
            resume_pad_d = 1'b0;
            if (widx_q == 4'd15) state_d = ST_SEND;
            else                 widx_d  = 4'(widx_q + 4'd1);
          end else begin
            wr_data      = pack_word;
            pend80_d     = pack_pend80;
            bitlen_d     = bitlen_q + LEN_W'({pack_nbytes, 3'b000});
            resume_pad_d = 1'b1;
            widx_d       = 4'(widx_q + 4'd1);
            state_d      = (widx_q == 4'd15) ? ST_SEND : ST_PAD;
          end
        end
      end
      ST_PAD: begin
        if (widx_q == 4'd14 && !pend80_q) begin
          state_d = ST_LEN_HI;
        end else begin
          wr_en    = 1'b1;
          wr_data  = pend80_q ? SHA1_PAD_WORD : 32'h0;
          pend80_d = 1'b0;
          if (widx_q == 4'd15) begin
            state_d      = ST_SEND;
            last_d       = 1'b0;
            resume_pad_d = 1'b1;
            widx_d       = 4'd0;
          end else begin
            widx_d = 4'(widx_q + 4'd1);
          end
        end
      end
      ST_LEN_HI: begin
        wr_en   = 1'b1;
        wr_idx  = 4'd14;
        wr_data = len64[63:32];
        state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        wr_en   = 1'b1;
        wr_idx  = 4'd15;
        wr_data = len64[31:0];
        last_d  = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: begin
        // A DONE level already high on entry is the previous block's; wait for a fresh edge.
        if (done_rise) begin
          buf_clr = 1'b1;
          widx_d  = 4'd0;
          first_d = 1'b0;
          if (last_q) begin
            MSG_DONE = 1'b1;
            first_d  = 1'b1;
            bitlen_d = '0;
            busy_d   = 1'b0;
            last_d   = 1'b0;
            state_d  = ST_FILL;
          end else begin
            state_d = resume_pad_q ? ST_PAD : ST_FILL;
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_FILL;
      widx_q       <= '0;
      bitlen_q     <= '0;
      first_q      <= 1'b1;
      last_q       <= 1'b0;
      pend80_q     <= 1'b0;
      resume_pad_q <= 1'b0;
      busy_q       <= 1'b0;
      done_prev_q  <= 1'b0;
      for (int i = 0; i < BLK_WORDS; i++) buf_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      widx_q       <= widx_d;
      bitlen_q     <= bitlen_d;
      first_q      <= first_d;
      last_q       <= last_d;
      pend80_q     <= pend80_d;
      resume_pad_q <= resume_pad_d;
      busy_q       <= busy_d;
      done_prev_q  <= CORE_DONE;
      if (buf_clr) begin
        for (int i = 0; i < BLK_WORDS; i++) buf_q[i] <= '0;
      end else if (wr_en) begin
        buf_q[wr_idx] <= wr_data;
      end
    end
  end

  always_comb begin
    BLK_OUT = '0;
    for (int i = 0; i < BLK_WORDS; i++) BLK_OUT[511-32*i -: 32] = buf_q[i];
  end

  assign DIN_READY   = (state_q == ST_FILL);
  assign BLK_START   = (state_q == ST_SEND);
  assign BLK_FIRST   = first_q & ((state_q == ST_SEND) | (state_q == ST_WAIT));
  assign BLK_LAST    = last_q  & ((state_q == ST_SEND) | (state_q == ST_WAIT));
  assign BUSY        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Directed bench for sha1_msg_padder: expected blocks are queued at stimulus
// time and a monitor checks each BLK_START against the queue head.
module tb_sha1_msg_padder;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  din;
  logic         din_valid, din_last;
  logic [2:0]   din_bytes;
  logic         din_ready;
  logic [511:0] blk_out;
  logic         blk_start, blk_first, blk_last;
  logic         core_done;
  logic         msg_done, busy;
  logic [2:0]   dbg_state;

  int total = 0;
  int bad   = 0;
  int msg_done_cnt = 0;
  bit auto_core = 1'b1;
  bit blk_pending = 1'b0;
  logic done_prev_tb = 1'b0;

  logic [513:0] exp_q[$];
  logic [31:0]  ew [16];

  sha1_msg_padder dut (
    .CLK        (clk),
    .RST        (rst),
    .DIN        (din),
    .DIN_VALID  (din_valid),
    .DIN_LAST   (din_last),
    .DIN_BYTES  (din_bytes),
    .DIN_READY  (din_ready),
    .BLK_OUT    (blk_out),
    .BLK_START  (blk_start),
    .BLK_FIRST  (blk_first),
    .BLK_LAST   (blk_last),
    .CORE_DONE  (core_done),
    .MSG_DONE   (msg_done),
    .BUSY       (busy),
    .dbg_state_o(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] pack_ew();
    logic [511:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b[511-32*i -: 32] = ew[i];
    return b;
  endfunction

  task automatic clear_ew();
    for (int i = 0; i < 16; i++) ew[i] = 32'h0;
  endtask

  task automatic push_exp(input logic f, input logic l);
    exp_q.push_back({f, l, pack_ew()});
  endtask

  // driver: hold the word until a cycle where DIN_READY is high
  task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] n);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    din = d; din_last = l; din_bytes = n; din_valid = 1'b1;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (din_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    din_valid = 1'b0; din_last = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_word timeout: got ready=0 expected ready=1");
    end
  endtask

  task automatic wait_done(input int target);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 600 && !ok; c++) begin
      @(negedge clk);
      if (msg_done_cnt >= target) ok = 1'b1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL msg_done timeout: got count=%0d expected %0d", msg_done_cnt, target);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ready"}, 512'(din_ready), 512'(1));
    chk({nm, "_start"}, 512'(blk_start), 512'(0));
    chk({nm, "_first"}, 512'(blk_first), 512'(0));
    chk({nm, "_last"},  512'(blk_last),  512'(0));
    chk({nm, "_mdone"}, 512'(msg_done),  512'(0));
    chk({nm, "_busy"},  512'(busy),      512'(0));
    chk({nm, "_blk"},   blk_out,         512'(0));
  endtask

  // scoreboard monitor
  initial begin
    logic [513:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (blk_pending) chk("ready_in_wait", 512'(din_ready), 512'(0));
        if (blk_pending && core_done && !done_prev_tb) blk_pending = 1'b0;
        if (msg_done) msg_done_cnt++;
        if (blk_start) begin
          blk_pending = 1'b1;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_block: got %h expected none", blk_out);
          end else begin
            e = exp_q.pop_front();
            chk("blk_out", blk_out, e[511:0]);
            chk("blk_first", 512'(blk_first), 512'(e[513]));
            chk("blk_last", 512'(blk_last), 512'(e[512]));
          end
        end
      end else begin
        blk_pending = 1'b0;
      end
      done_prev_tb = core_done;
    end
  end

  // core model: DONE a few cycles after each START
  initial begin
    forever begin
      @(negedge clk);
      if (blk_start && auto_core) begin
        repeat (3) @(posedge clk);
        #1 core_done = 1'b1;
        @(posedge clk);
        #1 core_done = 1'b0;
      end
    end
  end

  initial begin
    logic [511:0] abc_blk;
    bit stable, started;
    rst = 1'b1; din = '0; din_valid = 1'b0; din_last = 1'b0; din_bytes = '0;
    core_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // "abc", with stray DIN_VALID during padding that must be ignored
    clear_ew(); ew[0] = 32'h6162_6380; ew[15] = 32'h0000_0018;
    abc_blk = pack_ew();
    push_exp(1'b1, 1'b1);
    send_word(32'h6162_6300, 1'b1, 3'd3);
    din = 32'hDEAD_BEEF; din_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1 din_valid = 1'b0;
    wait_done(1);
    @(negedge clk);
    chk("busy_after_done", 512'(busy), 512'(0));
    chk("ready_after_done", 512'(din_ready), 512'(1));

    // empty message
    clear_ew(); ew[0] = 32'h8000_0000;
    push_exp(1'b1, 1'b1);
    send_word(32'h1234_5678, 1'b1, 3'd0);
    wait_done(2);

    // "hello" with junk in the unused bytes of the last word
    clear_ew(); ew[0] = 32'h6865_6c6c; ew[1] = 32'h6f80_0000; ew[15] = 32'h0000_0028;
    push_exp(1'b1, 1'b1);
    send_word(32'h6865_6c6c, 1'b0, 3'd4);
    send_word(32'h6fAA_BBCC, 1'b1, 3'd1);
    wait_done(3);

    // "hello!" : two valid bytes in the last word
    clear_ew(); ew[0] = 32'h6865_6c6c; ew[1] = 32'h6f21_8000; ew[15] = 32'h0000_0030;
    push_exp(1'b1, 1'b1);
    send_word(32'h6865_6c6c, 1'b0, 3'd4);
    send_word(32'h6f21_EEEE, 1'b1, 3'd2);
    wait_done(4);

    // 56 bytes: marker fills word 14, length spills into a second block
    clear_ew();
    for (int i = 0; i < 14; i++) ew[i] = 32'h0001_0203 + 32'(i) * 32'h0404_0404;
    ew[14] = 32'h8000_0000;
    push_exp(1'b1, 1'b0);
    clear_ew(); ew[15] = 32'h0000_01C0;
    push_exp(1'b0, 1'b1);
    for (int i = 0; i < 14; i++) begin
      send_word(32'h0001_0203 + 32'(i) * 32'h0404_0404, (i == 13), 3'd4);
      if (i == 0) chk("busy_mid_msg", 512'(busy), 512'(1));
    end
    wait_done(5);

    // 64 bytes: a full data block, then marker + length block
    clear_ew();
    for (int i = 0; i < 16; i++) ew[i] = 32'hA000_0000 + 32'(i);
    push_exp(1'b1, 1'b0);
    clear_ew(); ew[0] = 32'h8000_0000; ew[15] = 32'h0000_0200;
    push_exp(1'b0, 1'b1);
    for (int i = 0; i < 16; i++) send_word(32'hA000_0000 + 32'(i), (i == 15), 3'd4);
    wait_done(6);

    // stale DONE held across START, only the later rising edge counts
    auto_core = 1'b0;
    @(posedge clk); #1 core_done = 1'b1;
    exp_q.push_back({1'b1, 1'b1, abc_blk});
    send_word(32'h6162_6300, 1'b1, 3'd3);
    started = 1'b0;
    for (int c = 0; c < 100 && !started; c++) begin
      @(negedge clk);
      if (blk_start) started = 1'b1;
    end
    chk("stale_start_seen", 512'(started), 512'(1));
    @(posedge clk); #1 core_done = 1'b0;
    stable = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (blk_out !== abc_blk || msg_done !== 1'b0) stable = 1'b0;
    end
    chk("blk_stable_in_wait", 512'(stable), 512'(1));
    chk("no_done_on_stale", 512'(msg_done_cnt), 512'(6));
    @(posedge clk); #1 core_done = 1'b1;
    wait_done(7);
    @(posedge clk); #1 core_done = 1'b0;
    auto_core = 1'b1;

    // reset during PAD of a 20-byte message
    for (int i = 0; i < 5; i++) send_word(32'h5500_0000 + 32'(i), (i == 4), 3'd4);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("midreset");
    rst = 1'b0;
    clear_ew(); ew[0] = 32'h6162_6380; ew[15] = 32'h0000_0018;
    push_exp(1'b1, 1'b1);
    send_word(32'h6162_6300, 1'b1, 3'd3);
    wait_done(8);

    repeat (5) @(negedge clk);
    chk("queue_empty", 512'(exp_q.size()), 512'(0));
    chk("msg_done_total", 512'(msg_done_cnt), 512'(8));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha1_msg_padder.md
Name: sha1_msg_padder

Overview:
- Front end of the SHA-1 datapath: takes an arbitrary-length byte message as a 32-bit big-endian word stream.
- Applies FIPS 180 padding (0x80 marker, zero fill, 64-bit big-endian bit length) and assembles 512-bit blocks.
- Acts as initiator to the SHA-1 compression core: drives its 512-bit block input and START, then waits for its DONE before building the next block.
- Marks first and last blocks so the digest wrapper can re-initialise H and latch the final digest.

Parameters:
LEN_W, 64, width of internal bit-length counter; length field is zero-extended to 64 bits.
BLK_WORDS, 16, 32-bit words per block (fixed; parameter for readability only).

Ports:
CLK  in  1  clock, all logic on rising edge.
RST  in  1  synchronous, active-high reset.
DIN  in  32  message word, byte 0 in [31:24].
DIN_VALID  in  1  DIN valid.
DIN_LAST  in  1  final word of the message.
DIN_BYTES  in  3  valid bytes in last word, 0..4 (0 only for an empty message); ignored (treated as 4) when DIN_LAST=0.
DIN_READY  out  1  padder accepts DIN this cycle.
BLK_OUT  out  512  block to core, word 0 in [511:480].
BLK_START  out  1  one-cycle pulse: block valid, core begins.
BLK_FIRST  out  1  block is first of message; valid while BLK_START/WAIT.
BLK_LAST  out  1  block is final of message; valid while BLK_START/WAIT.
CORE_DONE  in  1  core finished current block; rising edge counts.
MSG_DONE  out  1  one-cycle pulse after last block's CORE_DONE.
BUSY  out  1  high from first accepted word until MSG_DONE.

Behaviour:
- Reset: state FILL, widx=0, bitlen=0, first=1, pend80=0, buffer zeroed; DIN_READY=1 (after reset), BLK_START=0, BLK_FIRST=0, BLK_LAST=0, MSG_DONE=0, BUSY=0, BLK_OUT=0.
- States: FILL, PAD, LEN_HI, LEN_LO, SEND, WAIT.
- FILL: DIN_READY=1. On DIN_VALID, store DIN at widx.
  - Not last: bitlen += 32; widx==15 -> SEND (more=1); else widx++.
  - Last with n=DIN_BYTES: store bytes 0..n-1, then for n<4 byte n=0x80 and remaining bytes 0; for n=4 set pend80. bitlen += 8*n. widx++ (wrapping at 16 -> SEND, resume in PAD) -> PAD.
- PAD, one word per cycle:
  - widx==14 and pend80=0 -> LEN_HI without writing.
  - Otherwise write (pend80 ? 0x80000000 : 0) at widx and clear pend80. widx==15 -> SEND (not last, resume PAD, widx=0); else widx++.
- LEN_HI writes word14 = bitlen[63:32]; LEN_LO writes word15 = bitlen[31:0] -> SEND with last=1.
- SEND: exactly one cycle.
  - BLK_START=1; BLK_FIRST=first; BLK_LAST=last.
  - BLK_OUT reflects the complete buffer from this cycle until CORE_DONE is seen; no buffer writes in SEND/WAIT.
  - -> WAIT.
- WAIT: DIN_READY=0. On CORE_DONE rising edge (prev=0, now=1):
  - first=0.
  - If last: MSG_DONE pulse, first=1, bitlen=0, BUSY=0 -> FILL.
  - Else resume FILL or PAD per stored resume flag.
  - Buffer cleared; widx=0.
- CORE_DONE high on entry to WAIT without a new rising edge is ignored (stale DONE from the previous block).
- Back-to-back messages: next message's words accepted the cycle after MSG_DONE.
- DIN_VALID outside FILL is ignored (not accepted, not stored).
- Reset mid-operation (any state): return to reset values immediately; a BLK_START in flight is dropped. The core shares RST.
- Minimum latency: last word accepted to BLK_START = (14-widx) PAD cycles + 2 LEN cycles + 1.

Decomposition:
- Package sha1_pkg:
  - state enum;
  - constants SHA1_BLK_W=512, SHA1_WORDS=16, SHA1_PAD_WORD=32'h80000000;
  - initial H constants, shared with the core and digest wrapper.
- Sub-module sha1_last_word_pack: combinational; DIN + DIN_BYTES -> masked word with 0x80 insertion, plus pend80 flag.

Test Plan:
- "abc" (DIN=0x61626300, LAST, BYTES=3) -> one block: w0=0x61626380, w1..w14=0, w15=0x00000018; FIRST=LAST=1. With the core connected, digest a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d.
- Empty message (LAST, BYTES=0) -> one block: w0=0x80000000, w1..w15=0; digest da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709.
- 56-byte message (14 full words, last BYTES=4) -> block1: w14=0x80000000, w15=0, FIRST=1, LAST=0. Block2: w0..w14=0, w15=0x000001C0, LAST=1.
- 64-byte message -> block1 is the 16 data words, LAST=0. Block2: w0=0x80000000, w15=0x00000200. DIN_READY=0 throughout both WAITs.
- CORE_DONE held high across BLK_START, then dropped, then re-pulsed after 100 cycles -> only the later edge advances. BLK_OUT stable for all 100 cycles.
- RST asserted during PAD of a 20-byte message -> next cycle all outputs at reset values. A following "abc" message yields the correct single block with FIRST=1.
